sd_read_arbiter: RTL

- Shares the single SD card read path between NUM_REQ independent clients, e.g. a sprite loader, an audio streamer and a level loader.
- Sits between the clients and the SD controller. It waits for card initialisation, grants one client at a time in round-robin order, issues a single 32-bit read, waits for completion or timeout, and returns data and status to the winning client.

---
 rtl/sd_read_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter
// Shares one SD card read path between NUM_REQ clients. After the SD
// controller reports initialisation, requesting clients are granted one at a
// time in round-robin order. Each grant issues a single 32-bit read, waits for
// completion or a timeout, and returns data/status to the granted client.
//
// Ports:
//   clk, reset      - SD clock domain, synchronous active-high reset
//   req             - per-client read request level
//   req_addr        - per-client read address, client i at [32*i +: 32]
//   grant           - one-hot owner of the SD path
//   rsp_valid       - one-cycle response pulse to the owning client
//   rsp_err         - 1 = read timed out, rsp_data invalid (0)
//   rsp_data        - read data, held until the next response
//   busy            - high in every state except IDLE
//   sd_init_done    - SD controller initialised and idle
//   sd_read_start   - read request to the SD controller
//   sd_addr         - read address to the SD controller
//   sd_data         - read data from the SD controller
//   sd_read_done    - single-cycle read completion pulse
module sd_read_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_err,
    output logic [31:0]            rsp_data,
    output logic                   busy,
    input  logic                   sd_init_done,
    output logic                   sd_read_start,
    output logic [31:0]            sd_addr,
    input  logic [31:0]            sd_data,
    input  logic                   sd_read_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] LAST_IDX   = PW'(NUM_REQ - 1);
    localparam logic [PW-1:0] PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    state_t               state_r;
    logic [PW-1:0]        rr_ptr_r;
    logic [PW-1:0]        winner_r;
    logic [TW-1:0]        timer_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   rsp_valid_r;
    logic                 rsp_err_r;
    logic [31:0]          rsp_data_r;
    logic                 busy_r;
    logic                 sd_read_start_r;
    logic [31:0]          sd_addr_r;

    logic                 found_s;
    logic [PW-1:0]        pick_idx_s;
    logic [NUM_REQ-1:0]   pick_oh_s;
    logic [31:0]          pick_addr_s;
    logic                 timeout_s;
    logic [TW-1:0]        timer_inc_s;

    // Round-robin search: first requesting index at or above ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [PW-1:0]      ptr);
        logic          found;
        logic          hit;
        logic [PW-1:0] idx;
        int            cand;
        found = 1'b0;
        idx   = {PW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand  = (int'(ptr) + k) % NUM_REQ;
            hit   = !found && r[cand[PW-1:0]];
            idx   = hit ? PW'(cand) : idx;
            found = found | hit;
        end
        return {found, idx};
    endfunction

    // Winner selection, its one-hot grant pattern and its address.
    always_comb begin
        {found_s, pick_idx_s} = rr_pick(req, rr_ptr_r);
        pick_addr_s = 32'h0000_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_oh_s[i] = found_s && (pick_idx_s == PW'(i));
            pick_addr_s  = pick_addr_s | (req_addr[32*i +: 32] & {32{pick_oh_s[i]}});
        end
    end

    // Timer increment (saturating) and timeout detection.
    always_comb begin
        timer_inc_s = (timer_r == TIMER_MAX) ? timer_r : (timer_r + TIMER_ONE);
        timeout_s   = (timer_r >= TIMER_LAST);
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= WAIT_INIT;
            rr_ptr_r        <= {PW{1'b0}};
            winner_r        <= {PW{1'b0}};
            timer_r         <= {TW{1'b0}};
            grant_r         <= {NUM_REQ{1'b0}};
            rsp_valid_r     <= {NUM_REQ{1'b0}};
            rsp_err_r       <= 1'b0;
            rsp_data_r      <= 32'h0000_0000;
            busy_r          <= 1'b1;
            sd_read_start_r <= 1'b0;
            sd_addr_r       <= 32'h0000_0000;
        end else begin
            case (state_r)
                WAIT_INIT: begin
                    if (sd_init_done) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                IDLE: begin
                    if (found_s) begin
                        state_r         <= ISSUE;
                        busy_r          <= 1'b1;
                        grant_r         <= pick_oh_s;
                        winner_r        <= pick_idx_s;
                        sd_addr_r       <= pick_addr_s;
                        sd_read_start_r <= 1'b1;
                        timer_r         <= {TW{1'b0}};
                    end
                end

                ISSUE, WAIT_DONE: begin
                    timer_r <= timer_inc_s;
                    // Completion has priority over a coincident timeout.
                    if (sd_read_done) begin
                        state_r         <= RESPOND;
                        rsp_data_r      <= sd_data;
                        rsp_err_r       <= 1'b0;
                        rsp_valid_r     <= grant_r;
                        sd_read_start_r <= 1'b0;
                    end else if (timeout_s) begin
                        state_r         <= RESPOND;
                        rsp_data_r      <= 32'h0000_0000;
                        rsp_err_r       <= 1'b1;
                        rsp_valid_r     <= grant_r;
                        sd_read_start_r <= 1'b0;
                    end else if ((state_r == ISSUE) && !sd_init_done) begin
                        // Controller has accepted the read and left idle.
                        state_r         <= WAIT_DONE;
                        sd_read_start_r <= 1'b0;
                    end
                end

                RESPOND: begin
                    rsp_valid_r <= {NUM_REQ{1'b0}};
                    grant_r     <= {NUM_REQ{1'b0}};
                    rr_ptr_r    <= (winner_r == LAST_IDX) ? {PW{1'b0}} : (winner_r + PTR_ONE);
                    // A timed-out controller may need to re-initialise.
                    if (rsp_err_r) begin
                        state_r <= WAIT_INIT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                default: begin
                    state_r         <= WAIT_INIT;
                    busy_r          <= 1'b1;
                    grant_r         <= {NUM_REQ{1'b0}};
                    rsp_valid_r     <= {NUM_REQ{1'b0}};
                    sd_read_start_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant         = grant_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_err       = rsp_err_r;
    assign rsp_data      = rsp_data_r;
    assign busy          = busy_r;
    assign sd_read_start = sd_read_start_r;
    assign sd_addr       = sd_addr_r;

endmodule
